// File: rtl/opcodes_pkg.sv
// opcodes_pkg -- shared decode types for the immediate decode stage.
//
// Contents:
//   opcode_out_t   : decoded opcode produced by the upstream opcode decoder
//   imm_fmt_t      : immediate format carried with each decoded entry
//   opcode_to_fmt  : maps a decoded opcode to its immediate format
//
// Configuration macro: IMM_ZICSR_EN
//   defined   -> format FMT_Z exists; CSRRWI/CSRRSI/CSRRCI classify as FMT_Z
//   undefined -> no FMT_Z; CSR immediate opcodes classify as FMT_NONE
package opcodes_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [4:0] {
    OPC_NONE,
    OPC_LUI,
    OPC_AUIPC,
    OPC_JAL,
    OPC_JALR,
    OPC_BEQ,
    OPC_BNE,
    OPC_BLT,
    OPC_BGE,
    OPC_BLTU,
    OPC_BGEU,
    OPC_LOAD,
    OPC_STORE,
    OPC_ADDI,
    OPC_SLTI,
    OPC_SLTIU,
    OPC_XORI,
    OPC_ORI,
    OPC_ANDI,
    OPC_SHIFTI,
    OPC_ALU_REG,
    OPC_FENCE,
    OPC_SYSTEM,
    OPC_CSRRW,
    OPC_CSRRS,
    OPC_CSRRC,
    OPC_CSRRWI,
    OPC_CSRRSI,
    OPC_CSRRCI
  } opcode_out_t;

`ifdef IMM_ZICSR_EN
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;
`else
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;
`endif

  // Register-form CSR ops, FENCE, SYSTEM and R-type carry no immediate we
  // forward, so they fall into FMT_NONE with everything unrecognised.
  function automatic imm_fmt_t opcode_to_fmt(input opcode_out_t op);
    imm_fmt_t fmt;
    fmt = FMT_NONE;
    case (op)
      OPC_LUI, OPC_AUIPC:                      fmt = FMT_U;
      OPC_JAL:                                 fmt = FMT_J;
      OPC_BEQ, OPC_BNE, OPC_BLT, OPC_BGE,
      OPC_BLTU, OPC_BGEU:                      fmt = FMT_B;
      OPC_STORE:                               fmt = FMT_S;
      OPC_JALR, OPC_LOAD, OPC_ADDI, OPC_SLTI,
      OPC_SLTIU, OPC_XORI, OPC_ORI, OPC_ANDI,
      OPC_SHIFTI:                              fmt = FMT_I;
`ifdef IMM_ZICSR_EN
      OPC_CSRRWI, OPC_CSRRSI, OPC_CSRRCI:      fmt = FMT_Z;
`endif
      default:                                 fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract -- combinational immediate builder.
//
// Ports:
//   instr : raw 32-bit instruction word
//   fmt   : immediate format chosen from the decoded opcode
//   imm   : XLEN-wide immediate, sign-extended from instr[31]
//           (FMT_Z, present only with IMM_ZICSR_EN, is zero-extended uimm)
//
// Parameters: XLEN (32 or 64).
module imm_extract
  import opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  imm_fmt_t           fmt,
  output logic [XLEN-1:0]    imm
);

  // Every format fits a sign-extended 32-bit value; widening to XLEN is
  // then a single signed cast.
  logic [31:0] imm32;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      // Bit 31 stays 0, so the signed widening below keeps it zero-extended.
      FMT_Z: imm32 = {27'b0, instr[19:15]};
`endif
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage -- immediate extraction + branch/jump target stage with a
// 2-entry in-order output FIFO and valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   flush                    : drop every buffered entry (and any same-cycle push)
//   in_valid / in_ready      : upstream handshake; in_ready = count < 2
//   opcode_in, instr_in,
//   pc_in, tag_in            : incoming decoded instruction
//   out_valid / out_ready    : downstream handshake; out_valid = count > 0
//   imm_out, fmt_out,
//   target_out, tag_out      : oldest buffered entry (target = pc + imm)
//
// Parameters: XLEN (32 or 64 only), TAG_W.
// Configuration macro: IMM_ZICSR_EN adds CSR immediate format FMT_Z, whose
// target_out is the zero-extended CSR address instr[31:20].
module imm_decode_stage
  import opcodes_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  opcode_out_t        opcode_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    imm_out,
  output imm_fmt_t           fmt_out,
  output logic [XLEN-1:0]    target_out,
  output logic [TAG_W-1:0]   tag_out
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_t         fmt;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] tag;
  } entry_t;

  imm_fmt_t        fmt_in;
  logic [XLEN-1:0] imm_in;
  logic [XLEN-1:0] target_in;
  entry_t          new_entry;

  // slot0 is always the oldest entry and drives the outputs directly.
  entry_t     slot0, slot1;
  entry_t     slot0_nxt, slot1_nxt;
  logic [1:0] count, count_nxt;
  logic [1:0] fill;
  logic       push, pop;

  assign fmt_in = opcode_to_fmt(opcode_in);

  imm_extract #(.XLEN(XLEN)) u_imm_extract (
    .instr (instr_in),
    .fmt   (fmt_in),
    .imm   (imm_in)
  );

  always_comb begin
    target_in = pc_in + imm_in;
`ifdef IMM_ZICSR_EN
    if (fmt_in == FMT_Z) target_in = XLEN'(instr_in[31:20]);
`endif
  end

  assign new_entry = '{imm: imm_in, fmt: fmt_in, target: target_in, tag: tag_in};

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The new entry lands in the first slot left free after this cycle's pop,
  // so push+pop at count 1 overwrites slot0 and keeps count at 1.
  assign fill = count - {1'b0, pop};

  always_comb begin
    slot0_nxt = pop ? slot1 : slot0;
    slot1_nxt = slot1;
    count_nxt = count + {1'b0, push} - {1'b0, pop};
    if (push) begin
      if (fill == 2'd0) slot0_nxt = new_entry;
      else              slot1_nxt = new_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      // NOTE: the storage slots are reset because slot0 is the visible
      // output and must read as zero/FMT_NONE; slot1 is cleared with it so
      // no X can ever shift into the outputs.
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count_nxt;
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
    end
  end

  assign imm_out    = slot0.imm;
  assign fmt_out    = slot0.fmt;
  assign target_out = slot0.target;
  assign tag_out    = slot0.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage -- self-checking bench for imm_decode_stage.
// Two instances (XLEN=32 and XLEN=64) share one input stream; expected
// entries come from an arithmetic immediate model and a queue-based FIFO model.
// Honours IMM_ZICSR_EN the same way the design does.
module tb_imm_decode_stage;
  import opcodes_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  opcode_out_t opcode_in = OPC_NONE;
  logic [31:0] instr_in = '0;
  logic [63:0] pc64 = '0;
  logic [3:0]  tag_in = '0;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32, target32;
  imm_fmt_t    fmt32;
  logic [3:0]  tag32;

  logic        in_ready64, out_valid64;
  logic [63:0] imm64, target64;
  imm_fmt_t    fmt64;
  logic [3:0]  tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    imm_fmt_t    fmt;
    logic [63:0] target;
    logic [3:0]  tag;
  } exp_t;

  exp_t model_q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .opcode_in(opcode_in), .instr_in(instr_in), .pc_in(pc64[31:0]), .tag_in(tag_in),
    .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm32), .fmt_out(fmt32), .target_out(target32), .tag_out(tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .opcode_in(opcode_in), .instr_in(instr_in), .pc_in(pc64), .tag_in(tag_in),
    .out_valid(out_valid64), .out_ready(out_ready),
    .imm_out(imm64), .fmt_out(fmt64), .target_out(target64), .tag_out(tag64)
  );

  // ---------------- reference model ----------------
  function automatic imm_fmt_t ref_fmt(opcode_out_t op);
    case (op)
      OPC_LUI, OPC_AUIPC: return FMT_U;
      OPC_JAL: return FMT_J;
      OPC_BEQ, OPC_BNE, OPC_BLT, OPC_BGE, OPC_BLTU, OPC_BGEU: return FMT_B;
      OPC_STORE: return FMT_S;
      OPC_JALR, OPC_LOAD, OPC_ADDI, OPC_SLTI, OPC_SLTIU,
      OPC_XORI, OPC_ORI, OPC_ANDI, OPC_SHIFTI: return FMT_I;
`ifdef IMM_ZICSR_EN
      OPC_CSRRWI, OPC_CSRRSI, OPC_CSRRCI: return FMT_Z;
`endif
      default: return FMT_NONE;
    endcase
  endfunction

  // Field values reassembled with shifts/weights, then two's-complement
  // correction when the sign bit is set.
  function automatic logic [63:0] ref_imm(imm_fmt_t f, logic [31:0] w);
    longint v;
    v = 0;
    case (f)
      FMT_I: begin
        v = longint'(w >> 20);
        if (w[31]) v -= 4096;
      end
      FMT_S: begin
        v = longint'((w >> 25) * 32) + longint'((w >> 7) & 32'd31);
        if (w[31]) v -= 4096;
      end
      FMT_B: begin
        v = longint'(((w >> 31) & 1) * 4096) + longint'(((w >> 7) & 1) * 2048)
          + longint'(((w >> 25) & 63) * 32) + longint'(((w >> 8) & 15) * 2);
        if (w[31]) v -= 8192;
      end
      FMT_U: begin
        v = longint'((w >> 12) * 4096);
        if (w[31]) v -= 64'sh1_0000_0000;
      end
      FMT_J: begin
        v = longint'(((w >> 31) & 1) * 1048576) + longint'(((w >> 12) & 255) * 4096)
          + longint'(((w >> 20) & 1) * 2048) + longint'(((w >> 21) & 1023) * 2);
        if (w[31]) v -= 2097152;
      end
`ifdef IMM_ZICSR_EN
      FMT_Z: v = longint'((w >> 15) & 32'd31);
`endif
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic exp_t ref_entry(opcode_out_t op, logic [31:0] w,
                                     logic [63:0] pc, logic [3:0] tag);
    exp_t e;
    e.fmt    = ref_fmt(op);
    e.imm    = ref_imm(e.fmt, w);
    e.target = pc + e.imm;
`ifdef IMM_ZICSR_EN
    if (e.fmt == FMT_Z) e.target = 64'(w >> 20);
`endif
    e.tag    = tag;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; tag_in = 4'hA;
    instr_in = 32'hFFF30293; opcode_in = OPC_ADDI; pc64 = 64'h100;
    tick();
    tick();
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 ||
        in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b/%b in_ready=%b/%b expected 0/0 1/1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    end
    checks++;
    if (imm32 !== '0 || imm64 !== '0 || target32 !== '0 || target64 !== '0 ||
        fmt32 !== FMT_NONE || fmt64 !== FMT_NONE || tag32 !== '0 || tag64 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: imm=%h/%h target=%h/%h fmt=%0d/%0d tag=%h/%h expected all zero",
               imm32, imm64, target32, target64, fmt32, fmt64, tag32, tag64);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    opcode_out_t op;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    imm_fmt_t    fmt;
    logic [63:0] target;
  } vec_t;

  task automatic test_vectors();
    vec_t v[6];
    v[0] = '{"addi", OPC_ADDI, 32'hFFF30293, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 64'hFF};
    v[1] = '{"beq",  OPC_BEQ,  32'hFE008CE3, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B, 64'hF8};
    v[2] = '{"jal",  OPC_JAL,  32'hFEDFF0EF, 64'h1000, 64'hFFFF_FFFF_FFFF_FFEC, FMT_J, 64'hFEC};
    v[3] = '{"lui",  OPC_LUI,  32'hABCDE0B7, 64'h0, 64'hFFFF_FFFF_ABCD_E000, FMT_U,
             64'hFFFF_FFFF_ABCD_E000};
    v[4] = '{"sw",   OPC_STORE, 32'hFE20AE23, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S,
             64'hFFFF_FFFF_FFFF_FFFC};
`ifdef IMM_ZICSR_EN
    v[5] = '{"csrrwi", OPC_CSRRWI, 32'h3002D0F3, 64'h200, 64'h5, FMT_Z, 64'h300};
`else
    v[5] = '{"csrrwi", OPC_CSRRWI, 32'h3002D0F3, 64'h200, 64'h0, FMT_NONE, 64'h200};
`endif
    do_reset();
    out_ready = 1'b1;
    foreach (v[i]) begin
      opcode_in = v[i].op; instr_in = v[i].instr; pc64 = v[i].pc;
      tag_in = 4'(i + 1); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid32 !== 1'b1 || imm32 !== v[i].imm[31:0] || fmt32 !== v[i].fmt ||
          target32 !== v[i].target[31:0]) begin
        errors++;
        $display("FAIL vec_%s_x32: valid=%b imm=%h fmt=%0d target=%h expected 1 %h %0d %h",
                 v[i].name, out_valid32, imm32, fmt32, target32,
                 v[i].imm[31:0], v[i].fmt, v[i].target[31:0]);
      end
      checks++;
      if (out_valid64 !== 1'b1 || imm64 !== v[i].imm || fmt64 !== v[i].fmt ||
          target64 !== v[i].target) begin
        errors++;
        $display("FAIL vec_%s_x64: valid=%b imm=%h fmt=%0d target=%h expected 1 %h %0d %h",
                 v[i].name, out_valid64, imm64, fmt64, target64,
                 v[i].imm, v[i].fmt, v[i].target);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got[$];
    do_reset();
    opcode_in = OPC_ADDI; instr_in = 32'h00100093; pc64 = 64'h40;
    out_ready = 1'b0; in_valid = 1'b1;
    tag_in = 4'd1; tick();
    tag_in = 4'd2; tick();
    checks++;
    if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0 || out_valid32 !== 1'b1 || tag32 !== 4'd1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b/%b out_valid=%b tag=%h expected 0/0 1 1",
               in_ready32, in_ready64, out_valid32, tag32);
    end
    tag_in = 4'd3; tick();   // refused push; head must be unchanged
    checks++;
    if (in_ready32 !== 1'b0 || tag32 !== 4'd1 || tag64 !== 4'd1) begin
      errors++;
      $display("FAIL bp_stall_stable: in_ready=%b tag=%h/%h expected 0 1/1",
               in_ready32, tag32, tag64);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid32) got.push_back(tag32);
      tick();
    end
    checks++;
    if (got.size() != 2 || got[0] !== 4'd1 || got[1] !== 4'd2) begin
      errors++;
      $display("FAIL bp_drain: got %0d tags first=%h second=%h expected 2 tags 1 2",
               got.size(), (got.size() > 0) ? got[0] : 4'hx, (got.size() > 1) ? got[1] : 4'hx);
    end
  endtask

  task automatic test_flush();
    int seen;
    do_reset();
    opcode_in = OPC_JAL; instr_in = 32'h0080006F; pc64 = 64'h80;
    out_ready = 1'b0; in_valid = 1'b1;
    tag_in = 4'd4; tick();
    tag_in = 4'd5; tick();
    checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
      errors++;
      $display("FAIL flush_prefill: in_ready=%b out_valid=%b expected 0 1", in_ready32, out_valid32);
    end
    flush = 1'b1; out_ready = 1'b1; tag_in = 4'd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b/%b in_ready=%b/%b expected 0/0 1/1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid32 || out_valid64) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_dropped: out_valid cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    opcode_in = OPC_LUI; instr_in = 32'h12345037; pc64 = 64'h10;
    out_ready = 1'b0; in_valid = 1'b1;
    tag_in = 4'd9; tick();
    tag_in = 4'd10; tick();
    rst = 1'b1; flush = 1'b1; tag_in = 4'd11;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== '0 || target32 !== '0 ||
        fmt32 !== FMT_NONE || tag32 !== '0 || imm64 !== '0 || tag64 !== '0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b ready=%b imm=%h target=%h fmt=%0d tag=%h expected 0 1 0 0 0 0",
               out_valid32, in_ready32, imm32, target32, fmt32, tag32);
    end
  endtask

  task automatic test_random_stream();
    int sz;
    exp_t h;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      opcode_in = opcode_out_t'($urandom_range(0, 28));
      instr_in  = $urandom;
      pc64      = {$urandom, $urandom};
      tag_in    = 4'($urandom);
      sz = model_q.size();
      checks++;
      if (out_valid32 !== (sz > 0) || out_valid64 !== (sz > 0) ||
          in_ready32 !== (sz < 2) || in_ready64 !== (sz < 2)) begin
        errors++;
        $display("FAIL rand_handshake cyc %0d: out_valid=%b/%b in_ready=%b/%b model count %0d",
                 c, out_valid32, out_valid64, in_ready32, in_ready64, sz);
      end
      if (sz > 0) begin
        h = model_q[0];
        checks++;
        if (imm32 !== h.imm[31:0] || fmt32 !== h.fmt || target32 !== h.target[31:0] || tag32 !== h.tag) begin
          errors++;
          $display("FAIL rand_head_x32 cyc %0d: imm=%h fmt=%0d target=%h tag=%h expected %h %0d %h %h",
                   c, imm32, fmt32, target32, tag32, h.imm[31:0], h.fmt, h.target[31:0], h.tag);
        end
        checks++;
        if (imm64 !== h.imm || fmt64 !== h.fmt || target64 !== h.target || tag64 !== h.tag) begin
          errors++;
          $display("FAIL rand_head_x64 cyc %0d: imm=%h fmt=%0d target=%h tag=%h expected %h %0d %h %h",
                   c, imm64, fmt64, target64, tag64, h.imm, h.fmt, h.target, h.tag);
        end
      end
      if (flush) begin
        model_q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(model_q.pop_front());
        if (in_valid && sz < 2) model_q.push_back(ref_entry(opcode_in, instr_in, pc64, tag_in));
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_priority();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
